// File: rtl/spi_slave_rx_fifo.sv
// rtl/spi_slave_rx_fifo.sv - oversampling SPI slave receiver with runtime mode/width/order and FWFT output FIFO
module spi_slave_rx_fifo #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 3,
    parameter int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              cfg_lsb_first,
    input  logic [5:0]        cfg_bits,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_first,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              partial_err,
    output logic              frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   clk_d;
    logic [SYNC_STAGES:0]   sync_vld;
    logic                   cs_armed;

    logic cs_s;
    logic clk_s;
    logic mosi_s;
    logic cs_fall;
    logic cs_rise;
    logic clk_rise;
    logic clk_fall;
    logic samp;

    // sync_vld tracks when cs_d holds a real pin value; a frame may only start after cs_n was seen high
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '1;
            clk_sync  <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b1;
            clk_d     <= 1'b0;
            sync_vld  <= '0;
            cs_armed  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_d      <= cs_s;
            clk_d     <= clk_s;
            sync_vld  <= {sync_vld[SYNC_STAGES-1:0], 1'b1};
            if (sync_vld[SYNC_STAGES] && cs_d) begin
                cs_armed <= 1'b1;
            end
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_armed & cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign clk_rise = ~clk_d & clk_s;
    assign clk_fall = clk_d & ~clk_s;

    logic [0:0]        state;
    logic [5:0]        bit_cnt;
    logic [5:0]        bits_lat;
    logic              cpol_lat;
    logic              cpha_lat;
    logic              lsb_lat;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nx;
    logic              first_flag;
    logic              word_rdy;
    logic              push_req;
    logic [DATA_W:0]   push_data;
    logic [5:0]        cfg_bits_eff;
    logic [5:0]        bit_cnt_inc;

    assign samp         = (cpol_lat == cpha_lat) ? clk_rise : clk_fall;
    assign cfg_bits_eff = (cfg_bits == 6'd0 || cfg_bits > 6'(DATA_W)) ? 6'(DATA_W) : cfg_bits;
    assign bit_cnt_inc  = bit_cnt + 6'd1;

    always_comb begin
        shift_nx = shift;
        if (lsb_lat) begin
            shift_nx = shift | (DATA_W'(mosi_s) << bit_cnt);
        end else begin
            shift_nx = {shift[DATA_W-2:0], mosi_s};
        end
    end

    // A completed word is held for one cycle in shift, then handed to the FIFO via push_req
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            bits_lat    <= 6'(DATA_W);
            cpol_lat    <= 1'b0;
            cpha_lat    <= 1'b0;
            lsb_lat     <= 1'b0;
            shift       <= '0;
            first_flag  <= 1'b0;
            word_rdy    <= 1'b0;
            push_req    <= 1'b0;
            push_data   <= '0;
            frame_done  <= 1'b0;
            partial_err <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            partial_err <= 1'b0;
            push_req    <= 1'b0;
            if (word_rdy) begin
                push_req   <= 1'b1;
                push_data  <= {first_flag, shift};
                word_rdy   <= 1'b0;
                bit_cnt    <= '0;
                shift      <= '0;
                first_flag <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state      <= ST_ACTIVE;
                        bit_cnt    <= '0;
                        shift      <= '0;
                        first_flag <= 1'b1;
                        bits_lat   <= cfg_bits_eff;
                        cpol_lat   <= cfg_cpol;
                        cpha_lat   <= cfg_cpha;
                        lsb_lat    <= cfg_lsb_first;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state       <= ST_IDLE;
                        frame_done  <= 1'b1;
                        partial_err <= (bit_cnt != 6'd0) && !word_rdy;
                        bit_cnt     <= '0;
                        shift       <= '0;
                    end else if (samp && !word_rdy) begin
                        shift   <= shift_nx;
                        bit_cnt <= bit_cnt_inc;
                        if (bit_cnt_inc == bits_lat) begin
                            word_rdy <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [DATA_W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LVL_W-1:0]   fifo_cnt;
    logic [DATA_W:0]    head;
    logic               full;
    logic               do_pop;
    logic               accept;
    logic               drop;

    assign full   = (fifo_cnt == LVL_W'(FIFO_DEPTH));
    assign do_pop = m_valid & m_ready;
    assign accept = push_req & (~full | do_pop);
    assign drop   = push_req & full & ~do_pop;

    always_ff @(posedge sys_clk) begin
        if (accept) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({accept, do_pop})
                2'b10:   fifo_cnt <= fifo_cnt + LVL_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - LVL_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Head is gated so stale memory never shows on the outputs while empty
    assign head       = mem[rd_ptr];
    assign m_valid    = (fifo_cnt != '0);
    assign m_data     = m_valid ? head[DATA_W-1:0] : '0;
    assign m_first    = m_valid ? head[DATA_W] : 1'b0;
    assign fifo_level = fifo_cnt;

endmodule

// File: tb/tb_spi_slave_rx_fifo.sv
// tb/tb_spi_slave_rx_fifo.sv - scoreboard bench for spi_slave_rx_fifo
module tb_spi_slave_rx_fifo;

    localparam int DW = 16;
    localparam int FD = 4;
    localparam int SS = 3;
    localparam int LW = 3;
    localparam int H  = 4;

    logic          sys_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_cpol = 1'b0;
    logic          cfg_cpha = 1'b0;
    logic          cfg_lsb_first = 1'b0;
    logic [5:0]    cfg_bits = 6'd8;
    logic          spi_cs_n = 1'b1;
    logic          spi_clk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_first;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic          partial_err;
    logic          frame_done;

    spi_slave_rx_fifo #(
        .DATA_W(DW), .FIFO_DEPTH(FD), .SYNC_STAGES(SS), .LVL_W(LW)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_lsb_first(cfg_lsb_first), .cfg_bits(cfg_bits),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_first(m_first),
        .fifo_level(fifo_level), .overflow(overflow), .ovf_clr(ovf_clr),
        .partial_err(partial_err), .frame_done(frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    logic [DW:0] sb [$];
    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int pe_cnt = 0;
    int pe_solo = 0;
    int rise_cyc = 0;
    int last_samp = 0;
    logic mv_q = 1'b0;
    logic cur_cpol = 1'b0;
    logic cur_cpha = 1'b0;
    logic cur_lsb = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (rst_n) begin
            mv_q <= m_valid;
            if (m_valid && !mv_q) rise_cyc <= cyc;
            if (frame_done) fd_cnt <= fd_cnt + 1;
            if (partial_err) pe_cnt <= pe_cnt + 1;
            if (partial_err && !frame_done) pe_solo <= pe_solo + 1;
            if (m_valid && m_ready) begin
                check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    logic [DW:0] e;
                    e = sb.pop_front();
                    check_eq("word", 32'({m_first, m_data}), 32'(e));
                end
            end
        end else begin
            mv_q <= 1'b0;
        end
    end

    task automatic wcyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic cs_start(input logic cpol, input logic cpha, input logic lsb, input logic [5:0] bits);
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb; cfg_bits = bits;
        cur_cpol = cpol; cur_cpha = cpha; cur_lsb = lsb;
        spi_clk = cpol;
        wcyc(6);
        spi_cs_n = 1'b0;
        wcyc(6);
    endtask

    task automatic cs_end();
        wcyc(6);
        spi_cs_n = 1'b1;
        wcyc(10);
    endtask

    // pop_hit: pulse m_ready for exactly the cycle the last word lands in the FIFO
    task automatic send_bits(input logic [DW-1:0] val, input int nb, input logic pop_hit);
        for (int i = 0; i < nb; i++) begin
            logic [DW-1:0] t;
            t = val >> (cur_lsb ? i : nb - 1 - i);
            if (!cur_cpha) begin
                spi_mosi = t[0];
                wcyc(H);
                spi_clk = ~cur_cpol;
            end else begin
                spi_clk = ~cur_cpol;
                spi_mosi = t[0];
                wcyc(H);
                spi_clk = cur_cpol;
            end
            last_samp = cyc;
            if (pop_hit && i == nb - 1) begin
                wcyc(5);
                m_ready = 1'b1;
                wcyc(1);
                m_ready = 1'b0;
            end else begin
                wcyc(H);
            end
            spi_clk = cur_cpol;
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 400 && sb.size() != 0; k++) wcyc(1);
        wcyc(2);
        check_eq(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int fd0, pe0;
        wcyc(4);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_m_first", 32'(m_first), 32'd0);
        check_eq("rst_level", 32'(fifo_level), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_partial", 32'(partial_err), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        wcyc(10);

        // mode 0, MSB first, single word, plus latency
        m_ready = 1'b1;
        fd0 = fd_cnt; pe0 = pe_cnt;
        cs_start(1'b0, 1'b0, 1'b0, 6'd8);
        sb.push_back({1'b1, 16'h00A5});
        send_bits(16'h00A5, 8, 1'b0);
        cs_end();
        wait_drain("drain_a5");
        check_eq("latency", 32'(rise_cyc - last_samp), 32'(SS + 3));
        check_eq("a5_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check_eq("a5_partial", 32'(pe_cnt - pe0), 32'd0);

        for (int m = 0; m < 4; m++) begin
            logic [1:0] mm;
            mm = m[1:0];
            cs_start(mm[1], mm[0], 1'b0, 6'd8);
            sb.push_back({1'b1, 16'h003C});
            sb.push_back({1'b0, 16'h00C3});
            send_bits(16'h003C, 8, 1'b0);
            send_bits(16'h00C3, 8, 1'b0);
            cs_end();
            wait_drain($sformatf("drain_mode%0d", m));
        end

        cs_start(1'b0, 1'b0, 1'b1, 6'd12);
        sb.push_back({1'b1, 16'h0ABC});
        send_bits(16'h0ABC, 12, 1'b0);
        cs_end();
        wait_drain("drain_lsb12");

        // cfg_bits 0 falls back to full width
        cs_start(1'b1, 1'b1, 1'b0, 6'd0);
        sb.push_back({1'b1, 16'hBEEF});
        send_bits(16'hBEEF, 16, 1'b0);
        cs_end();
        wait_drain("drain_bits0");

        fd0 = fd_cnt; pe0 = pe_cnt;
        cs_start(1'b0, 1'b0, 1'b0, 6'd8);
        send_bits(16'h0015, 5, 1'b0);
        cs_end();
        check_eq("trunc_partial", 32'(pe_cnt - pe0), 32'd1);
        check_eq("trunc_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check_eq("trunc_same_cycle", 32'(pe_solo), 32'd0);
        check_eq("trunc_level", 32'(fifo_level), 32'd0);

        m_ready = 1'b0;
        cs_start(1'b0, 1'b0, 1'b0, 6'd8);
        for (int k = 0; k < 6; k++) begin
            logic [DW-1:0] w;
            w = 16'(8'h11 * (k + 1));
            if (k < 4) sb.push_back({(k == 0), w});
            send_bits(w, 8, 1'b0);
        end
        cs_end();
        check_eq("ovf_level", 32'(fifo_level), 32'd4);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        wcyc(1);
        ovf_clr = 1'b0;
        check_eq("ovf_cleared", 32'(overflow), 32'd0);
        cs_start(1'b0, 1'b0, 1'b0, 6'd8);
        sb.push_back({1'b1, 16'h0077});
        send_bits(16'h0077, 8, 1'b1);
        cs_end();
        check_eq("fullpop_overflow", 32'(overflow), 32'd0);
        check_eq("fullpop_level", 32'(fifo_level), 32'd4);
        check_eq("fullpop_sb", 32'(sb.size()), 32'd4);
        m_ready = 1'b1;
        wait_drain("drain_ovf");
        check_eq("ovf_drained_level", 32'(fifo_level), 32'd0);

        // reset in the middle of a word with one word buffered
        m_ready = 1'b0;
        cs_start(1'b0, 1'b0, 1'b0, 6'd8);
        send_bits(16'h005A, 8, 1'b0);
        send_bits(16'h000F, 4, 1'b0);
        wcyc(8);
        check_eq("pre_rst_level", 32'(fifo_level), 32'd1);
        rst_n = 1'b0;
        wcyc(3);
        check_eq("midrst_m_valid", 32'(m_valid), 32'd0);
        check_eq("midrst_m_data", 32'(m_data), 32'd0);
        check_eq("midrst_level", 32'(fifo_level), 32'd0);
        check_eq("midrst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        wcyc(6);
        send_bits(16'h00FF, 8, 1'b0);
        wcyc(10);
        check_eq("cs_low_at_release", 32'(fifo_level), 32'd0);
        spi_cs_n = 1'b1;
        wcyc(10);

        m_ready = 1'b1;
        pe0 = pe_cnt;
        cs_start(1'b0, 1'b0, 1'b0, 6'd8);
        cfg_bits = 6'd4;
        sb.push_back({1'b1, 16'h0096});
        send_bits(16'h0096, 8, 1'b0);
        cs_end();
        cfg_bits = 6'd8;
        wait_drain("drain_cfgchg");
        check_eq("cfgchg_partial", 32'(pe_cnt - pe0), 32'd0);

        check_eq("sb_final", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
